// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    // A request is rejected when it is not word aligned or falls past the array.
    function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
        logic [31:0] upper_s;
        upper_s = addr >> (addr_w + 2);
        return (addr[1:0] != 2'b00) || (upper_s != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data array with byte-lane writes and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit,
    input  logic              write,
    input  logic              block,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_r [2**ADDR_W];
    logic [31:0] rdata_r;

    // Byte-lane store; the array has no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (commit && write && !block) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register doubles as the response data; stores and errors return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= 32'd0;
        end else if (commit) begin
            rdata_r <= (write || block) ? 32'd0 : mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with a configurable number of wait states
// between request acceptance and the registered response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

    state_e           state_r;
    state_e           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    logic             hold_write_r;
    logic [31:0]      hold_addr_r;
    logic [31:0]      hold_wdata_r;
    logic [3:0]       hold_be_r;

    logic             rsp_valid_r;
    logic             rsp_err_r;

    logic             accept_s;
    logic             handshake_s;
    logic             commit_s;

    logic             sel_write_s;
    logic [31:0]      sel_addr_s;
    logic [31:0]      sel_wdata_s;
    logic [3:0]       sel_be_s;
    logic             sel_err_s;

    assign req_ready   = (state_r == ST_IDLE);
    assign accept_s    = req_valid && req_ready;
    assign handshake_s = rsp_valid_r && rsp_ready;

    // A zero-wait accept commits from the live inputs; otherwise the holding registers feed the commit.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_write_s = req_write;
            sel_addr_s  = req_addr;
            sel_wdata_s = req_wdata;
            sel_be_s    = req_be;
        end else begin
            sel_write_s = hold_write_r;
            sel_addr_s  = hold_addr_r;
            sel_wdata_s = hold_wdata_r;
            sel_be_s    = hold_be_r;
        end
        sel_err_s = addr_err(sel_addr_s, ADDR_W);
    end

    // Next-state, wait counter and commit strobe.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_s = WAIT_CNT;
                    if (WAIT_CNT == 4'd0) begin
                        commit_s = 1'b1;
                        state_s  = ST_RESP;
                    end else begin
                        state_s  = ST_WAIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    commit_s = 1'b1;
                    state_s  = ST_RESP;
                end else begin
                    state_s  = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (handshake_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and counter registers; reset drops any request still waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Holding registers isolate the commit from request inputs changing while busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_write_r <= 1'b0;
            hold_addr_r  <= 32'd0;
            hold_wdata_r <= 32'd0;
            hold_be_r    <= 4'd0;
        end else if (accept_s) begin
            hold_write_r <= req_write;
            hold_addr_r  <= req_addr;
            hold_wdata_r <= req_wdata;
            hold_be_r    <= req_be;
        end
    end

    // Response flags are set at commit and held until the response handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
        end else if (commit_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= sel_err_s;
        end else if (handshake_s) begin
            rsp_valid_r <= 1'b0;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .commit (commit_s),
        .write  (sel_write_s),
        .block  (sel_err_s),
        .be     (sel_be_s),
        .addr   (sel_addr_s[ADDR_W+1:2]),
        .wdata  (sel_wdata_s),
        .rdata  (rsp_rdata)
    );

    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized traffic
// scored against a word-array model of the memory.
module tb_dmem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        r0_req_valid, r0_req_ready, r0_req_write;
    logic [31:0] r0_req_addr, r0_req_wdata;
    logic [3:0]  r0_req_be;
    logic        r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
    logic [31:0] r0_rsp_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] ref_mem [1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(10), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(r0_req_valid), .req_ready(r0_req_ready), .req_write(r0_req_write),
        .req_addr(r0_req_addr), .req_wdata(r0_req_wdata), .req_be(r0_req_be),
        .rsp_valid(r0_rsp_valid), .rsp_ready(r0_rsp_ready),
        .rsp_rdata(r0_rsp_rdata), .rsp_err(r0_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: word array, updated only by in-range aligned stores.
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] exp_rd, output logic exp_err);
        int word;
        exp_err = ((a % 32'd4) != 32'd0) || (a >= 32'h0000_1000);
        exp_rd  = 32'd0;
        if (!exp_err) begin
            word = int'(a / 32'd4);
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) ref_mem[word][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                exp_rd = ref_mem[word];
            end
        end
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int hold, output logic [31:0] rd_seen);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] rd0;
        logic        err0;
        int          lat;
        model(w, a, d, be, exp_rd, exp_err);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        check("latency", 32'(lat), 32'(WS + 1));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_rdata", rsp_rdata, exp_rd);
        rd_seen = rsp_rdata;
        rd0 = rsp_rdata;
        err0 = rsp_err;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, rd0);
            check("bp_err", 32'(rsp_err), 32'(err0));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_after_hs", 32'(req_ready), 32'd1);
        check("valid_after_hs", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d0 [4];
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        int          sel;
        int          n;
        int          t_prev;
        int          t_now;

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        rsp_ready = 1'b0;
        r0_req_valid = 1'b0; r0_req_write = 1'b0; r0_req_addr = 32'd0; r0_req_wdata = 32'd0;
        r0_req_be = 4'd0; r0_rsp_ready = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Basic store/load and byte enables
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        txn(1'b0, 32'h10, 32'd0, 4'h0, 0, rd);
        check("load_0x10", rd, 32'hDEADBEEF);
        txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
        txn(1'b0, 32'h20, 32'd0, 4'h0, 0, rd);
        check("be_merge", rd, 32'h11BB33DD);

        // Errors leave memory untouched
        txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd);
        txn(1'b0, 32'h13, 32'd0, 4'h0, 0, rd);
        txn(1'b1, 32'h0000_1000, 32'h99999999, 4'hF, 0, rd);
        txn(1'b0, 32'h0, 32'd0, 4'h0, 0, rd);
        check("no_write_on_err", rd, 32'hCAFEF00D);

        // Backpressure for five cycles
        txn(1'b0, 32'h10, 32'd0, 4'h0, 5, rd);

        // Reset during WAIT of a store
        txn(1'b1, 32'h40, 32'h12345678, 4'hF, 0, rd);
        txn(1'b0, 32'h10, 32'd0, 4'h0, 0, rd);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        check("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        txn(1'b0, 32'h40, 32'd0, 4'h0, 0, rd);
        check("dropped_store", rd, 32'h12345678);

        // Zero wait states: back-to-back with rsp_ready held high
        for (int i = 0; i < 4; i++) d0[i] = $urandom;
        r0_rsp_ready = 1'b1;
        r0_req_valid = 1'b1;
        t_prev = 0;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            r0_req_write = (k < 4);
            r0_req_addr  = 32'(k % 4) * 32'd4;
            r0_req_wdata = d0[k % 4];
            r0_req_be    = 4'hF;
            n = 0;
            while (!r0_req_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("ws0_ready", 32'(r0_req_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            t_now = cyc;
            check("ws0_valid", 32'(r0_rsp_valid), 32'd1);
            check("ws0_err", 32'(r0_rsp_err), 32'd0);
            check("ws0_rdata", r0_rsp_rdata, (k < 4) ? 32'd0 : d0[k % 4]);
            if (k > 0) check("ws0_period", 32'(t_now - t_prev), 32'd2);
            t_prev = t_now;
        end
        r0_req_valid = 1'b0;
        @(negedge clk);

        // Randomized traffic against the model
        for (int i = 0; i < 16; i++) txn(1'b1, 32'(i) * 32'd4, $urandom, 4'hF, 0, rd);
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            n   = $urandom_range(0, 15);
            w   = 1'($urandom_range(0, 1));
            wd  = $urandom;
            if (sel < 8)
                a = 32'(n) * 32'd4;
            else if (sel == 8)
                a = 32'(n) * 32'd4 + 32'($urandom_range(1, 3));
            else
                a = (32'(n) * 32'd4) | (32'd1 << $urandom_range(12, 31));
            txn(w, a, wd, 4'($urandom), $urandom_range(0, 3), rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
